ir_tx_queue_bus_interface: RTL and testbench
============================================

Name: ir_tx_queue_bus_interface

Overview:
Next-generation bus slave for the IR car transmitter. It replaces the single command register with a register map, a command FIFO and per-command car selection. A sequencer feeds commands to the existing IR transmitter core over a valid/ready handshake, in one-shot or repeat-with-hold mode. The block sits on the processor bus at BASE_ADDR..BASE_ADDR+3, between the bus and the IR transmitter core.

Parameters:
BUS_WIDTH, 8, bus data/address width
BASE_ADDR, 8'h90, first register address
CAR_COUNT, 4, number of selectable cars; CAR_W = max(1, $clog2(CAR_COUNT))
CMD_LEN, 4, command width (CMD_LEN <= BUS_WIDTH)
FIFO_DEPTH, 4, command FIFO entries, power of two >= 2
HOLD_PACKETS, 8, repeat-mode packets before auto-stop; 0 = repeat forever

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
BUS_DATA  inout  BUS_WIDTH  shared data bus; driven only during reads
BUS_ADDR  in  BUS_WIDTH  bus address
BUS_WE  in  1  bus write enable
TX_CMD  out  CMD_LEN  command offered to transmitter core
TX_CAR  out  CAR_W  car offered to transmitter core
TX_VALID  out  1  offer valid
TX_READY  in  1  core accepts the offer (packet start)

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 CMD: W pushes {CAR_SEL, data[CMD_LEN-1:0]} into the FIFO; R returns the last command transferred.
  - +1 CAR_SEL: R/W, low CAR_W bits.
  - +2 CTRL: bit0 ENABLE, bit1 MODE (0 one-shot, 1 repeat), bit2 FLUSH (write-1, self-clearing, reads 0).
  - +3 STATUS (RO): bit0 empty, bit1 full, bit2 busy (FSM != IDLE), bit3 overflow (sticky), bits[7:4] FIFO count (saturating).
- Reads:
  - Registered; data appears 1 cycle after the address matches with BUS_WE=0.
  - BUS_DATA is hi-Z otherwise; unused bits read 0.
- Reset values: every register 0; TX_VALID=0; TX_CMD=0; TX_CAR=0; FIFO empty; FSM IDLE; BUS_DATA hi-Z.
- Transfer occurs when TX_VALID & TX_READY on the same rising edge.
  - TX_CMD and TX_CAR are held stable while TX_VALID=1.
  - TX_VALID may be withdrawn without a transfer only by ENABLE clear (REPEAT state) or FLUSH.
- FIFO:
  - Push when full: entry dropped, overflow set.
  - Push and pop in the same cycle: both occur, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A STATUS read clears overflow after returning the pre-clear value.
- FSM:
  - IDLE: if ENABLE & !empty, pop the head into TX_CMD/TX_CAR and go to SEND. TX_VALID=1 from the next cycle.
  - SEND, on transfer:
    - MODE=0: go to IDLE (TX_VALID=0 next cycle). The next FIFO entry is issued after one bubble cycle.
    - MODE=1: go to REPEAT, with hold_cnt=0.
  - SEND, ENABLE cleared: the pending offer is kept until it transfers, then go to IDLE.
  - REPEAT: TX_VALID=1 with the same command.
    - If !empty: pop the new head, clear hold_cnt, go to SEND. FIFO priority applies over hold expiry in the same cycle.
    - Else, on each transfer: hold_cnt++. When hold_cnt reaches HOLD_PACKETS (HOLD_PACKETS != 0), go to IDLE with TX_VALID=0 next cycle.
    - ENABLE=0: go to IDLE next cycle.
  - hold_cnt is $clog2(HOLD_PACKETS+1) bits wide and never wraps.
- FLUSH:
  - Empties the FIFO, clears overflow, forces IDLE and TX_VALID=0 next cycle.
  - A transfer in the same cycle as FLUSH still counts as completed; no further offer follows.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). TX_VALID drops without a handshake.

Optional Feature:
IR_TX_IRQ_EN
- Defined:
  - Adds ports BUS_INTERRUPT_RAISE (out, 1) and BUS_INTERRUPT_ACK (in, 1).
  - RAISE is set, level and sticky, when the FSM enters IDLE from SEND/REPEAT with the FIFO empty.
  - RAISE clears on the cycle after ACK=1; ACK takes priority over a simultaneous set.
  - RAISE resets to 0.
- Undefined: ports absent; no other behaviour change.

Test Plan:
- Reset, then read STATUS -> 8'h01 (empty) one cycle after the address; BUS_DATA hi-Z on all non-read cycles.
- CAR_SEL=2, CTRL=8'h01, write CMD=4'h5, TX_READY high on the 3rd cycle of TX_VALID -> TX_CMD=5 and TX_CAR=2 stable until the transfer, TX_VALID low the cycle after.
- ENABLE=0, write CMD 5 times with FIFO_DEPTH=4 -> STATUS=8'h4A. A second STATUS read -> 8'h42 (overflow cleared).
- CTRL=8'h03, CMD=4'h3, TX_READY pulsed every 10 cycles -> exactly 1+8 transfers of 3, then IDLE, busy=0. Variant: push 4'h6 during REPEAT -> the next offer is 6, hold restarts.
- FIFO holds 3 entries, TX_VALID high; write CTRL=8'h04 -> TX_VALID=0 next cycle, STATUS=8'h01 next read, FLUSH bit reads 0.
- Drive RESET low while in REPEAT with TX_VALID=1 -> TX_VALID=0, TX_CMD=0 within the same cycle, no clock edge required. With IR_TX_IRQ_EN, RAISE=0.

Source files
------------

// File: rtl/ir_tx_queue_bus_interface_if.sv
// rtl/ir_tx_queue_bus_interface_if.sv - bus address/strobe and transmitter handshake bundle
// IRQ signals exist only when IR_TX_IRQ_EN is defined.
interface ir_tx_queue_bus_interface_if #(
  parameter int BUS_WIDTH = 8,
  parameter int CMD_LEN   = 4,
  parameter int CAR_W     = 2
);
  logic [BUS_WIDTH-1:0] BUS_ADDR;
  logic                 BUS_WE;
  logic [CMD_LEN-1:0]   TX_CMD;
  logic [CAR_W-1:0]     TX_CAR;
  logic                 TX_VALID;
  logic                 TX_READY;
`ifdef IR_TX_IRQ_EN
  logic                 BUS_INTERRUPT_RAISE;
  logic                 BUS_INTERRUPT_ACK;
`endif

  modport slave (
`ifdef IR_TX_IRQ_EN
    output BUS_INTERRUPT_RAISE,
    input  BUS_INTERRUPT_ACK,
`endif
    input  BUS_ADDR, BUS_WE, TX_READY,
    output TX_CMD, TX_CAR, TX_VALID
  );

  modport master (
`ifdef IR_TX_IRQ_EN
    input  BUS_INTERRUPT_RAISE,
    output BUS_INTERRUPT_ACK,
`endif
    output BUS_ADDR, BUS_WE, TX_READY,
    input  TX_CMD, TX_CAR, TX_VALID
  );
endinterface

// File: rtl/ir_tx_queue_bus_interface.sv
// rtl/ir_tx_queue_bus_interface.sv - register map, command FIFO and one-shot/repeat sequencer for the IR transmitter
// Optional sticky completion interrupt is built when IR_TX_IRQ_EN is defined.
module ir_tx_queue_bus_interface #(
  parameter int                   BUS_WIDTH    = 8,
  parameter logic [BUS_WIDTH-1:0] BASE_ADDR    = 8'h90,
  parameter int                   CAR_COUNT    = 4,
  parameter int                   CMD_LEN      = 4,
  parameter int                   FIFO_DEPTH   = 4,
  parameter int                   HOLD_PACKETS = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  inout  wire  [BUS_WIDTH-1:0] BUS_DATA,
  ir_tx_queue_bus_interface_if.slave bus
);
  localparam int CAR_W = (CAR_COUNT > 1) ? $clog2(CAR_COUNT) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int HW    = (HOLD_PACKETS > 0) ? $clog2(HOLD_PACKETS + 1) : 1;
  localparam int EW    = CAR_W + CMD_LEN;

  typedef enum logic [1:0] {IDLE, SEND, REPEAT} state_t;

  state_t               state;
  logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic                 enable, mode, overflow;
  logic [CAR_W-1:0]     car_sel;
  logic [CMD_LEN-1:0]   last_cmd, tx_cmd;
  logic [CAR_W-1:0]     tx_car;
  logic                 tx_valid;
  logic [HW-1:0]        hold_cnt;
  logic [BUS_WIDTH-1:0] rd_data;
  logic                 rd_oe;

  logic [BUS_WIDTH-1:0] off;
  logic hit, wr_cmd, wr_car, wr_ctrl, flush, rd, rd_status;
  logic empty, full, xfer, pop, push;
  logic [3:0]           cnt_sat;
  logic [EW-1:0]        head;

  assign off       = bus.BUS_ADDR - BASE_ADDR;
  assign hit       = (off[BUS_WIDTH-1:2] == '0);
  assign wr_cmd    = hit &  bus.BUS_WE & (off[1:0] == 2'd0);
  assign wr_car    = hit &  bus.BUS_WE & (off[1:0] == 2'd1);
  assign wr_ctrl   = hit &  bus.BUS_WE & (off[1:0] == 2'd2);
  assign flush     = wr_ctrl & BUS_DATA[2];
  assign rd        = hit & ~bus.BUS_WE;
  assign rd_status = rd & (off[1:0] == 2'd3);

  assign empty   = (count == '0);
  assign full    = (int'(count) == FIFO_DEPTH);
  assign cnt_sat = (int'(count) > 15) ? 4'hf : 4'(count);
  assign head    = fifo_mem[rd_ptr];
  assign xfer    = tx_valid & bus.TX_READY;
  assign pop     = ~flush & enable & ~empty & ((state == IDLE) | (state == REPEAT));
  // a push into a full FIFO still lands when the head leaves in the same cycle
  assign push    = wr_cmd & (~full | pop);

  wire unused_bus_bits = ^BUS_DATA;

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {car_sel, BUS_DATA[CMD_LEN-1:0]};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b0;
      mode     <= 1'b0;
      car_sel  <= '0;
    end else begin
      if (wr_car)  car_sel <= BUS_DATA[CAR_W-1:0];
      if (wr_ctrl) {mode, enable} <= BUS_DATA[1:0];
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
        if (wr_cmd & ~push)  overflow <= 1'b1;
        else if (rd_status)  overflow <= 1'b0;
      end
    end
  end

  // Read data is captured on the strobe edge and driven for the following cycle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_oe   <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_oe   <= rd;
      rd_data <= '0;
      case (off[1:0])
        2'd0: rd_data[CMD_LEN-1:0] <= last_cmd;
        2'd1: rd_data[CAR_W-1:0]   <= car_sel;
        2'd2: rd_data[1:0]         <= {mode, enable};
        default: begin
          rd_data[0]   <= empty;
          rd_data[1]   <= full;
          rd_data[2]   <= (state != IDLE);
          rd_data[3]   <= overflow;
          rd_data[7:4] <= cnt_sat;
        end
      endcase
    end
  end

  assign BUS_DATA = rd_oe ? rd_data : 'z;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_cmd   <= '0;
      tx_car   <= '0;
      hold_cnt <= '0;
      last_cmd <= '0;
    end else begin
      if (xfer) last_cmd <= tx_cmd;
      if (flush) begin
        state    <= IDLE;
        tx_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (pop) begin
            {tx_car, tx_cmd} <= head;
            tx_valid         <= 1'b1;
            state            <= SEND;
          end
          SEND: if (xfer) begin
            if (enable & mode) begin
              state    <= REPEAT;
              hold_cnt <= '0;
            end else begin
              state    <= IDLE;
              tx_valid <= 1'b0;
            end
          end
          REPEAT: begin
            if (!enable) begin
              state    <= IDLE;
              tx_valid <= 1'b0;
            end else if (pop) begin
              {tx_car, tx_cmd} <= head;
              hold_cnt         <= '0;
              state            <= SEND;
            end else if (xfer) begin
              if (HOLD_PACKETS != 0 && int'(hold_cnt) + 1 == HOLD_PACKETS) begin
                state    <= IDLE;
                tx_valid <= 1'b0;
              end
              if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            tx_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.TX_CMD   = tx_cmd;
  assign bus.TX_CAR   = tx_car;
  assign bus.TX_VALID = tx_valid;

`ifdef IR_TX_IRQ_EN
  logic was_busy, raise;
  // Raised the cycle after landing in IDLE from an active state with nothing queued
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      was_busy <= 1'b0;
      raise    <= 1'b0;
    end else begin
      was_busy <= (state != IDLE);
      if (bus.BUS_INTERRUPT_ACK)                    raise <= 1'b0;
      else if (was_busy && state == IDLE && empty)  raise <= 1'b1;
    end
  end
  assign bus.BUS_INTERRUPT_RAISE = raise;
`endif
endmodule

// File: tb/tb_ir_tx_queue_bus_interface.sv
// tb/tb_ir_tx_queue_bus_interface.sv - directed self-checking bench for ir_tx_queue_bus_interface
module tb_ir_tx_queue_bus_interface;
  localparam logic [7:0] A_CMD = 8'h90, A_CAR = 8'h91, A_CTRL = 8'h92, A_STAT = 8'h93;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       drv = 1'b0;
  logic [7:0] drv_data = 8'h00;
  wire  [7:0] BUS_DATA;
  int         checks = 0;
  int         errors = 0;

  assign BUS_DATA = drv ? drv_data : 'z;

  ir_tx_queue_bus_interface_if #(.BUS_WIDTH(8), .CMD_LEN(4), .CAR_W(2)) bus_if ();

  ir_tx_queue_bus_interface dut (
    .CLK(CLK), .RESET(RESET), .BUS_DATA(BUS_DATA), .bus(bus_if)
  );

  always #5 CLK = ~CLK;

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    bus_if.BUS_ADDR = a; bus_if.BUS_WE = 1'b1; drv_data = d; drv = 1'b1;
    @(negedge CLK);
    bus_if.BUS_WE = 1'b0; drv = 1'b0; bus_if.BUS_ADDR = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge CLK);
    bus_if.BUS_ADDR = a; bus_if.BUS_WE = 1'b0;
    @(negedge CLK);
    bus_if.BUS_ADDR = 8'h00;
    #1 d = BUS_DATA;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.TX_VALID) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  task automatic pulse_run(input int cycles, input logic [3:0] want, output int n_xfer, output int n_bad);
    n_xfer = 0; n_bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      bus_if.TX_READY = (c % 10 == 9);
      #1;
      if (bus_if.TX_VALID && bus_if.TX_READY) begin
        n_xfer++;
        if (bus_if.TX_CMD != want) n_bad++;
      end
    end
    @(negedge CLK);
    bus_if.TX_READY = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    #1;
    checks++; if (bus_if.TX_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus_if.TX_VALID); end
    checks++; if (bus_if.TX_CMD !== 4'h0) begin errors++; $display("FAIL reset_cmd got %h want 0", bus_if.TX_CMD); end
    checks++; if (bus_if.TX_CAR !== 2'h0) begin errors++; $display("FAIL reset_car got %h want 0", bus_if.TX_CAR); end
    @(negedge CLK); RESET = 1'b1;
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL reset_status got %h want 01", d); end
    @(negedge CLK); drv_data = 8'hA5; drv = 1'b1; #1;
    checks++; if (BUS_DATA !== 8'hA5) begin errors++; $display("FAIL bus_release got %h want a5", BUS_DATA); end
    drv = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [7:0] d;
    bit ok;
    bus_write(A_CAR, 8'h02);
    bus_write(A_CTRL, 8'h01);
    bus_write(A_CMD, 8'h05);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL oneshot_valid_timeout got 0 want 1"); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus_if.TX_CMD !== 4'h5 || bus_if.TX_CAR !== 2'h2 || bus_if.TX_VALID !== 1'b1) begin
        errors++; $display("FAIL oneshot_hold%0d got cmd %h car %h v %b want 5 2 1", k, bus_if.TX_CMD, bus_if.TX_CAR, bus_if.TX_VALID);
      end
      if (k == 2) bus_if.TX_READY = 1'b1;
      else @(negedge CLK);
    end
    @(negedge CLK); bus_if.TX_READY = 1'b0; #1;
    checks++; if (bus_if.TX_VALID !== 1'b0) begin errors++; $display("FAIL oneshot_drop got %b want 0", bus_if.TX_VALID); end
    bus_read(A_CMD, d);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL oneshot_lastcmd got %h want 05", d); end
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL oneshot_status got %h want 01", d); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    bus_write(A_CTRL, 8'h00);
    for (int i = 1; i <= 5; i++) bus_write(A_CMD, 8'(i));
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h4A) begin errors++; $display("FAIL overflow_status got %h want 4a", d); end
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h42) begin errors++; $display("FAIL overflow_cleared got %h want 42", d); end
    @(negedge CLK); drv_data = 8'h3C; drv = 1'b1; #1;
    checks++; if (BUS_DATA !== 8'h3C) begin errors++; $display("FAIL read_release got %h want 3c", BUS_DATA); end
    drv = 1'b0;
    bus_write(A_CTRL, 8'h04);
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL overflow_flush got %h want 01", d); end
  endtask

  task automatic test_repeat();
    logic [7:0] d;
    int n, bad;
    bit ok;
    bus_write(A_CTRL, 8'h03);
    bus_write(A_CMD, 8'h03);
    pulse_run(115, 4'h3, n, bad);
    checks++; if (n != 9 || bad != 0) begin errors++; $display("FAIL repeat_count got %0d bad %0d want 9 bad 0", n, bad); end
    checks++; if (bus_if.TX_VALID !== 1'b0) begin errors++; $display("FAIL repeat_stop got %b want 0", bus_if.TX_VALID); end
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL repeat_idle_status got %h want 01", d); end
    bus_write(A_CMD, 8'h03);
    wait_valid(ok);
    pulse_run(10, 4'h3, n, bad);
    checks++; if (!ok || n != 1) begin errors++; $display("FAIL repeat_first got %0d want 1", n); end
    @(negedge CLK); #1;
    checks++; if (bus_if.TX_VALID !== 1'b1 || bus_if.TX_CMD !== 4'h3) begin errors++; $display("FAIL repeat_hold got v %b cmd %h want 1 3", bus_if.TX_VALID, bus_if.TX_CMD); end
    bus_write(A_CMD, 8'h06);
    @(negedge CLK); #1;
    checks++; if (bus_if.TX_VALID !== 1'b1 || bus_if.TX_CMD !== 4'h6) begin errors++; $display("FAIL repeat_newcmd got v %b cmd %h want 1 6", bus_if.TX_VALID, bus_if.TX_CMD); end
    pulse_run(115, 4'h6, n, bad);
    checks++; if (n != 9 || bad != 0) begin errors++; $display("FAIL repeat_restart got %0d bad %0d want 9 bad 0", n, bad); end
  endtask

  task automatic test_flush();
    logic [7:0] d;
    bit ok;
    bus_write(A_CTRL, 8'h00);
    for (int i = 7; i <= 10; i++) bus_write(A_CMD, 8'(i));
    bus_write(A_CTRL, 8'h01);
    wait_valid(ok);
    bus_read(A_STAT, d);
    checks++; if (!ok || d !== 8'h34) begin errors++; $display("FAIL flush_pre_status got %h want 34", d); end
    checks++; if (bus_if.TX_CMD !== 4'h7) begin errors++; $display("FAIL flush_head got %h want 7", bus_if.TX_CMD); end
    bus_write(A_CTRL, 8'h04);
    #1;
    checks++; if (bus_if.TX_VALID !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus_if.TX_VALID); end
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL flush_status got %h want 01", d); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL flush_ctrl got %h want 00", d); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    int n, bad;
    bit ok;
    bus_write(A_CAR, 8'h03);
    bus_write(A_CTRL, 8'h03);
    bus_write(A_CMD, 8'h0B);
    wait_valid(ok);
    pulse_run(10, 4'hB, n, bad);
    checks++; if (!ok || n != 1 || bus_if.TX_VALID !== 1'b1 || bus_if.TX_CAR !== 2'h3) begin
      errors++; $display("FAIL areset_setup got n %0d v %b car %h want 1 1 3", n, bus_if.TX_VALID, bus_if.TX_CAR);
    end
    #2 RESET = 1'b0;
    #1;
    checks++; if (bus_if.TX_VALID !== 1'b0 || bus_if.TX_CMD !== 4'h0 || bus_if.TX_CAR !== 2'h0) begin
      errors++; $display("FAIL areset_outputs got v %b cmd %h car %h want 0 0 0", bus_if.TX_VALID, bus_if.TX_CMD, bus_if.TX_CAR);
    end
`ifdef IR_TX_IRQ_EN
    checks++; if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin errors++; $display("FAIL areset_irq got %b want 0", bus_if.BUS_INTERRUPT_RAISE); end
`endif
    @(negedge CLK); RESET = 1'b1;
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL areset_status got %h want 01", d); end
    bus_read(A_CAR, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL areset_car got %h want 00", d); end
  endtask

  initial begin
    bus_if.BUS_ADDR = 8'h00;
    bus_if.BUS_WE   = 1'b0;
    bus_if.TX_READY = 1'b0;
`ifdef IR_TX_IRQ_EN
    bus_if.BUS_INTERRUPT_ACK = 1'b0;
`endif
    test_reset();
    test_one_shot();
    test_overflow();
    test_repeat();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
